// File: rtl/nf_10g_rx_meta_tagger.sv
// Store-and-forward 10G receive stage: buffers whole frames, measures length and emits NetFPGA TUSER.
// Optional build macro NF_RX_TAGGER_RUNT_DROP_EN drops frames shorter than 60 bytes.
module nf_10g_rx_meta_tagger #(
    parameter int C_DATA_WIDTH    = 64,
    parameter int C_TUSER_WIDTH   = 128,
    parameter int DATA_DEPTH_LOG2 = 9,
    parameter int META_DEPTH_LOG2 = 5
) (
    input  logic                        core_clk,
    input  logic                        rst,
    input  logic [7:0]                  interface_number,
    input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [31:0]                 drop_count,
    input  logic                        drop_count_clear
);
    localparam int KEEP_W     = C_DATA_WIDTH / 8;
    localparam int DATA_DEPTH = 1 << DATA_DEPTH_LOG2;
    localparam int META_DEPTH = 1 << META_DEPTH_LOG2;
    localparam int ENTRY_W    = 1 + KEEP_W + C_DATA_WIDTH;
    localparam int META_W     = 24;
    localparam logic [DATA_DEPTH_LOG2-1:0] DPTR_ONE = 1;

    typedef enum logic [1:0] {ST_RESYNC, ST_IDLE, ST_ACCEPT, ST_DROP} wr_state_t;

    logic [ENTRY_W-1:0]         data_mem [DATA_DEPTH];
    logic [META_W-1:0]          meta_mem [META_DEPTH];
    logic [DATA_DEPTH_LOG2-1:0] wr_ptr_reg, commit_ptr_reg, rd_ptr_reg, wr_ptr_inc;
    logic [META_DEPTH_LOG2:0]   meta_wr_reg, meta_rd_reg;
    wr_state_t                  state_reg;
    logic [15:0]                len_reg, len_next;
    logic [7:0]                 ifnum_reg, ifnum_cur;
    logic [31:0]                drop_count_reg;
    logic [C_DATA_WIDTH-1:0]    m_data_reg;
    logic [KEEP_W-1:0]          m_keep_reg;
    logic [C_TUSER_WIDTH-1:0]   m_user_reg, tuser_load;
    logic                       m_valid_reg, m_last_reg;
    logic                       data_full, meta_full, runt_frame, commit_ok;
    logic                       accepting, mem_we, commit_frame, drop_frame;
    logic                       out_free, data_avail, load, meta_pop;
    logic [META_DEPTH_LOG2-1:0] meta_load_idx;

    function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < KEEP_W; i++) c = c + {15'd0, k[i]};
        return c;
    endfunction

    // Fullness is judged on registered pointers only, one slot kept empty.
    assign wr_ptr_inc = wr_ptr_reg + DPTR_ONE;
    assign data_full  = (wr_ptr_inc == rd_ptr_reg);
    assign meta_full  = (meta_wr_reg[META_DEPTH_LOG2] != meta_rd_reg[META_DEPTH_LOG2]) &&
                        (meta_wr_reg[META_DEPTH_LOG2-1:0] == meta_rd_reg[META_DEPTH_LOG2-1:0]);
    assign ifnum_cur  = (state_reg == ST_IDLE) ? interface_number : ifnum_reg;
    assign len_next   = ((state_reg == ST_IDLE) ? 16'd0 : len_reg) +
                        (s_axis_tlast ? popcount(s_axis_tkeep) : 16'(KEEP_W));

`ifdef NF_RX_TAGGER_RUNT_DROP_EN
    assign runt_frame = (len_next < 16'd60);
`else
    assign runt_frame = 1'b0;
`endif

    assign commit_ok    = !meta_full && !runt_frame;
    assign accepting    = s_axis_tvalid && (state_reg == ST_IDLE || state_reg == ST_ACCEPT);
    assign mem_we       = accepting && !data_full;
    assign commit_frame = mem_we && s_axis_tlast && commit_ok;
    assign drop_frame   = (accepting && s_axis_tlast && (data_full || !commit_ok)) ||
                          (state_reg == ST_DROP && s_axis_tvalid && s_axis_tlast);

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_reg      <= s_axis_tvalid ? ST_RESYNC : ST_IDLE;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            meta_wr_reg    <= '0;
            len_reg        <= '0;
            ifnum_reg      <= '0;
        end else begin
            case (state_reg)
                ST_RESYNC: if (s_axis_tvalid && s_axis_tlast) state_reg <= ST_IDLE;
                ST_IDLE, ST_ACCEPT: begin
                    if (s_axis_tvalid) begin
                        if (data_full) begin
                            // An overflowing tlast beat ends the frame here rather than eating the next one.
                            if (s_axis_tlast) begin
                                wr_ptr_reg <= commit_ptr_reg;
                                state_reg  <= ST_IDLE;
                            end else begin
                                state_reg  <= ST_DROP;
                            end
                        end else begin
                            len_reg   <= len_next;
                            ifnum_reg <= ifnum_cur;
                            if (s_axis_tlast) begin
                                state_reg <= ST_IDLE;
                                if (commit_ok) begin
                                    wr_ptr_reg     <= wr_ptr_inc;
                                    commit_ptr_reg <= wr_ptr_inc;
                                    meta_wr_reg    <= meta_wr_reg + 1'b1;
                                end else begin
                                    wr_ptr_reg     <= commit_ptr_reg;
                                end
                            end else begin
                                wr_ptr_reg <= wr_ptr_inc;
                                state_reg  <= ST_ACCEPT;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        wr_ptr_reg <= commit_ptr_reg;
                        state_reg  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (mem_we) data_mem[wr_ptr_reg] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (commit_frame) meta_mem[meta_wr_reg[META_DEPTH_LOG2-1:0]] <= {ifnum_cur, len_next};
    end

    always_ff @(posedge core_clk) begin
        if (rst || drop_count_clear) drop_count_reg <= '0;
        else if (drop_frame && drop_count_reg != 32'hFFFF_FFFF) drop_count_reg <= drop_count_reg + 32'd1;
    end

    // While the held beat is a departing tlast, the next frame's metadata sits one entry further on.
    assign out_free      = !m_valid_reg || m_axis_tready;
    assign data_avail    = (rd_ptr_reg != commit_ptr_reg);
    assign load          = out_free && data_avail;
    assign meta_pop      = m_valid_reg && m_axis_tready && m_last_reg;
    assign meta_load_idx = meta_rd_reg[META_DEPTH_LOG2-1:0] +
                           {{(META_DEPTH_LOG2-1){1'b0}}, (m_valid_reg && m_last_reg)};

    always_comb begin
        tuser_load          = '0;
        tuser_load[23:0]    = meta_mem[meta_load_idx];
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_data_reg  <= '0;
            m_keep_reg  <= '0;
            m_user_reg  <= '0;
            rd_ptr_reg  <= '0;
            meta_rd_reg <= '0;
        end else begin
            if (load) begin
                {m_last_reg, m_keep_reg, m_data_reg} <= data_mem[rd_ptr_reg];
                m_user_reg  <= tuser_load;
                m_valid_reg <= 1'b1;
                rd_ptr_reg  <= rd_ptr_reg + DPTR_ONE;
            end else if (out_free) begin
                m_valid_reg <= 1'b0;
            end
            meta_rd_reg <= meta_rd_reg + {{META_DEPTH_LOG2{1'b0}}, meta_pop};
        end
    end

    assign s_axis_tready = !rst;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tkeep  = m_keep_reg;
    assign m_axis_tuser  = m_user_reg;
    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tlast  = m_last_reg;
    assign drop_count    = drop_count_reg;
endmodule
